// File: rtl/sysbus_scheduler.sv
// Round-robin arbiter sharing one Sysbus between the icache and dcache.
// Grants one requester, forwards its request or write burst, and routes the 8-beat read response back.
module sysbus_scheduler #(
   parameter int WIDTH     = 64,
   parameter int TAG_WIDTH = 13,
   parameter int BEATS     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_reqcyc,
   input  logic [WIDTH-1:0]     i_req,
   input  logic [TAG_WIDTH-1:0] i_reqtag,
   output logic                 i_reqack,
   output logic                 i_respcyc,
   output logic [WIDTH-1:0]     i_resp,
   output logic [TAG_WIDTH-1:0] i_resptag,
   input  logic                 d_reqcyc,
   input  logic [WIDTH-1:0]     d_req,
   input  logic [TAG_WIDTH-1:0] d_reqtag,
   output logic                 d_reqack,
   output logic                 d_respcyc,
   output logic [WIDTH-1:0]     d_resp,
   output logic [TAG_WIDTH-1:0] d_resptag,
   output logic                 d_writeack,
   output logic                 bus_reqcyc,
   output logic [WIDTH-1:0]     bus_req,
   output logic [TAG_WIDTH-1:0] bus_reqtag,
   input  logic                 bus_reqack,
   input  logic                 bus_respcyc,
   input  logic [WIDTH-1:0]     bus_resp,
   input  logic [TAG_WIDTH-1:0] bus_resptag,
   output logic                 bus_respack
);

   localparam int CNT_W = $clog2(BEATS) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_I_REQ, S_I_RESP, S_D_REQ, S_D_RESP, S_D_WRITE
   } state_t;

   state_t                 state_q, state_d;
   logic                   last_grant_q, last_grant_d;   // 1 = dcache held the bus last
   logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic                   i_respcyc_q, i_respcyc_d;
   logic [WIDTH-1:0]       i_resp_q, i_resp_d;
   logic [TAG_WIDTH-1:0]   i_resptag_q, i_resptag_d;
   logic                   d_respcyc_q, d_respcyc_d;
   logic [WIDTH-1:0]       d_resp_q, d_resp_d;
   logic [TAG_WIDTH-1:0]   d_resptag_q, d_resptag_d;
   logic                   d_writeack_q, d_writeack_d;
   logic                   req_accept;

   assign req_accept = bus_reqcyc & bus_reqack;

   // Request path is a pure pass-through so the cache sees its ack in the same cycle as the bus.
   always_comb begin
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      i_reqack    = 1'b0;
      d_reqack    = 1'b0;
      bus_respack = 1'b0;
      case (state_q)
         S_I_REQ: begin
            bus_reqcyc = i_reqcyc;
            bus_req    = i_req;
            bus_reqtag = i_reqtag;
            i_reqack   = i_reqcyc & bus_reqack;
         end
         S_D_REQ, S_D_WRITE: begin
            bus_reqcyc = d_reqcyc;
            bus_req    = d_req;
            bus_reqtag = d_reqtag;
            d_reqack   = d_reqcyc & bus_reqack;
         end
         S_I_RESP, S_D_RESP: bus_respack = bus_respcyc;
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      i_respcyc_d  = 1'b0;
      i_resp_d     = '1;
      i_resptag_d  = i_resptag_q;
      d_respcyc_d  = 1'b0;
      d_resp_d     = '1;
      d_resptag_d  = d_resptag_q;
      d_writeack_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_reqcyc && (!d_reqcyc || last_grant_q)) begin
               state_d      = S_I_REQ;
               last_grant_d = 1'b0;
               beat_cnt_d   = '0;
            end else if (d_reqcyc) begin
               state_d      = d_reqtag[TAG_WIDTH-1] ? S_D_REQ : S_D_WRITE;
               last_grant_d = 1'b1;
               beat_cnt_d   = '0;
            end
         end
         S_I_REQ: begin
            if (req_accept) begin
               state_d    = S_I_RESP;
               beat_cnt_d = '0;
            end
         end
         S_D_REQ: begin
            if (req_accept) begin
               state_d    = S_D_RESP;
               beat_cnt_d = '0;
            end
         end
         S_I_RESP: begin
            if (bus_respcyc) begin
               i_respcyc_d = 1'b1;
               i_resp_d    = bus_resp;
               i_resptag_d = bus_resptag;
               beat_cnt_d  = beat_cnt_q + CNT_ONE;
               if (beat_cnt_q == LAST_BEAT) state_d = S_IDLE;
            end
         end
         S_D_RESP: begin
            if (bus_respcyc) begin
               d_respcyc_d = 1'b1;
               d_resp_d    = bus_resp;
               d_resptag_d = bus_resptag;
               beat_cnt_d  = beat_cnt_q + CNT_ONE;
               if (beat_cnt_q == LAST_BEAT) state_d = S_IDLE;
            end
         end
         S_D_WRITE: begin
            // A dropped d_reqcyc stalls the burst without leaving the grant.
            if (req_accept) begin
               beat_cnt_d = beat_cnt_q + CNT_ONE;
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d      = S_IDLE;
                  d_writeack_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         beat_cnt_q   <= '0;
         i_respcyc_q  <= 1'b0;
         i_resp_q     <= '1;
         i_resptag_q  <= '0;
         d_respcyc_q  <= 1'b0;
         d_resp_q     <= '1;
         d_resptag_q  <= '0;
         d_writeack_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         i_respcyc_q  <= i_respcyc_d;
         i_resp_q     <= i_resp_d;
         i_resptag_q  <= i_resptag_d;
         d_respcyc_q  <= d_respcyc_d;
         d_resp_q     <= d_resp_d;
         d_resptag_q  <= d_resptag_d;
         d_writeack_q <= d_writeack_d;
      end
   end

   assign i_respcyc  = i_respcyc_q;
   assign i_resp     = i_resp_q;
   assign i_resptag  = i_resptag_q;
   assign d_respcyc  = d_respcyc_q;
   assign d_resp     = d_resp_q;
   assign d_resptag  = d_resptag_q;
   assign d_writeack = d_writeack_q;

endmodule

// File: doc/sysbus_scheduler.md
# sysbus_scheduler

Round-robin scheduler that shares the single Sysbus between the instruction-cache and data-cache requesters. It grants one requester at a time, passes its request header or 8-beat write burst onto the bus, counts the 8-beat read response and routes it back to the granted cache, then releases the bus. It sits between the L1 caches and the Sysbus.

## Interface
- WIDTH, 64: data/request width.
- TAG_WIDTH, 13: tag width; bit TAG_WIDTH-1 = 1 read, 0 write.
- BEATS, 8: beats per read response and per write burst.

- clk  in  1  bus clock.
- reset  in  1  synchronous, active-high.
- i_reqcyc  in  1  icache request valid (reads only).
- i_req  in  WIDTH  icache request address.
- i_reqtag  in  TAG_WIDTH  icache request tag.
- i_reqack  out  1  icache request accepted.
- i_respcyc  out  1  icache response beat valid.
- i_resp  out  WIDTH  icache response data.
- i_resptag  out  TAG_WIDTH  icache response tag.
- d_reqcyc, d_req, d_reqtag, d_reqack, d_respcyc, d_resp, d_resptag: same as icache set, for dcache; reads and writes.
- d_writeack  out  1  one-cycle pulse when a dcache write burst completes.
- bus_reqcyc  out  1  Sysbus request valid.
- bus_req  out  WIDTH  Sysbus request address/data.
- bus_reqtag  out  TAG_WIDTH  Sysbus request tag.
- bus_reqack  in  1  Sysbus accepted current request beat.
- bus_respcyc  in  1  Sysbus response beat valid.
- bus_resp  in  WIDTH  Sysbus response data.
- bus_resptag  in  TAG_WIDTH  Sysbus response tag.
- bus_respack  out  1  response beat accepted.

## Operation
- States: IDLE, I_REQ, I_RESP, D_REQ, D_RESP, D_WRITE.
- IDLE: if exactly one reqcyc is high, grant it. If both are high, grant the requester not recorded in last_grant. Go to I_REQ, D_REQ (dcache tag bit = 1) or D_WRITE (bit = 0). Update last_grant.
- Request states, combinational pass-through from the granted requester:
  - bus_reqcyc = granted reqcyc.
  - bus_req and bus_reqtag = granted req and reqtag.
  - granted reqack = bus_reqcyc & bus_reqack.
- In all other states: bus_reqcyc = 0, bus_req/bus_reqtag = 0, both reqack = 0.
- I_REQ/D_REQ: on an accepted beat (bus_reqcyc & bus_reqack), go to I_RESP/D_RESP and clear beat_cnt.
- *_RESP: bus_respack = bus_respcyc. Each beat is registered to the granted cache: respcyc = 1, resp = bus_resp, resptag = bus_resptag. beat_cnt increments per beat. On beat BEATS (cnt = BEATS-1 and respcyc), go to IDLE.
- D_WRITE: each accepted beat increments beat_cnt. If d_reqcyc drops mid-burst, bus_reqcyc drops and beat_cnt holds; the state stays D_WRITE. On beat BEATS accepted, go to IDLE and pulse d_writeack for one cycle (registered).
- Responses are routed by grant state, not by tag. A bus_respcyc outside *_RESP gets bus_respack = 0 and is not forwarded.
- Non-granted cache: reqack = 0, respcyc = 0, resp = all ones.
- Registered resp outputs when no beat: respcyc = 0, resp = all ones, resptag holds.
- beat_cnt is 4 bits for BEATS = 8 (clog2(BEATS)+1). It never wraps; it clears on grant.

## Timing
- Reset values:
  - state = IDLE, last_grant = dcache (icache wins the first tie).
  - beat_cnt = 0.
  - i_respcyc = d_respcyc = 0, i_resp = d_resp = all ones, resptags = 0.
  - d_writeack = 0.
  - Combinational outputs are 0 in IDLE.
- Reset mid-transaction aborts it. No writeack is issued; the bus sees bus_reqcyc = 0 the following cycle.
- Grant latency: requester reqcyc rising in cycle N → bus_reqcyc high in cycle N+1.
- Request ack is same-cycle with bus_reqack (combinational). The requester must hold req and reqtag until it sees reqack.
- Response latency: bus beat in cycle N → cache respcyc/resp in cycle N+1. bus_respack is in cycle N.
- Last read beat in cycle N → state IDLE in N+1; next grant earliest N+2.
- Last write beat accepted in cycle N → d_writeack high only in N+1; state IDLE in N+1.
- Minimum one IDLE cycle between transactions.

## Test plan
- Reset then idle: all outputs at reset values; d_writeack = 0; bus_reqcyc = 0 for 10 cycles.
- Icache read of addr 0x1000, tag 0x1001; bus acks 2 cycles later and returns 8 beats 0..7 → i_reqack 1 cycle; i_resp = 0..7 each one cycle after its bus beat; d_respcyc stays 0; IDLE after beat 8.
- Dcache write of 8 beats 0xA0..0xA7, tag bit 12 = 0, with bus_reqack stalled every other cycle → 8 d_reqack pulses in order; d_writeack pulses once the cycle after beat 8.
- Both reqcyc high in the same cycle, 3 back-to-back rounds → grants alternate i, d, i starting with icache after reset.
- Reset asserted during beat 4 of a dcache read → next cycle state IDLE, d_respcyc = 0, no further beats forwarded.
- Stray bus_respcyc while IDLE → bus_respack = 0; i_respcyc = d_respcyc = 0.
